// File: rtl/axis_sync_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_sync_fifo_if                                                  |
// | AXI-Stream in/out handshake plus fill-level bus for axis_sync_fifo |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface axis_sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid;
  logic             o_tready;
  logic [SIZE:0]    space;
  logic [SIZE:0]    occupied;

  // Producer/consumer side of the FIFO.
  modport master (
    output i_tdata, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tvalid, space, occupied
  );

  // FIFO side.
  modport slave (
    input  i_tdata, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tvalid, space, occupied
  );
endinterface
`default_nettype wire

// File: rtl/axis_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axis_sync_fifo                                                     |
// | Single-clock FWFT AXI-Stream FIFO, 2^SIZE words in block RAM       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  axis_sync_fifo_if.slave      bus
);

  localparam logic [SIZE:0] c_DEPTH = {{SIZE{1'b0}}, 1'b1} << SIZE;
  localparam logic [SIZE:0] c_ONE   = {{SIZE{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [0:(1<<SIZE)-1];
  logic [SIZE-1:0]  r_wr_ptr;
  logic [SIZE-1:0]  r_rd_ptr;
  logic [SIZE:0]    r_occupied;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_accept;
  logic             w_consume;
  logic [SIZE:0]    w_ram_count;
  logic             w_rd_en;
  logic [SIZE:0]    w_occ_next;

  assign w_accept    = bus.i_tvalid & r_in_ready;
  assign w_consume   = r_out_valid & bus.o_tready;
  // Words still in RAM exclude the one already presented on the output.
  assign w_ram_count = r_occupied - {{SIZE{1'b0}}, r_out_valid};
  assign w_rd_en     = (w_ram_count != '0) & (~r_out_valid | w_consume);

  always_comb begin
    w_occ_next = r_occupied;
    case ({w_accept, w_consume})
      2'b10:   w_occ_next = r_occupied + c_ONE;
      2'b01:   w_occ_next = r_occupied - c_ONE;
      default: w_occ_next = r_occupied;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occupied  <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occupied  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_occupied <= w_occ_next;
      r_in_ready <= (w_occ_next < c_DEPTH);
      if (w_rd_en) begin
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Storage and its registered read port; the read register is the FWFT stage.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus.i_tdata;
    end
    if (w_rd_en) begin
      r_out_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.i_tready = r_in_ready;
  assign bus.o_tvalid = r_out_valid;
  assign bus.o_tdata  = r_out_data;
  assign bus.occupied = r_occupied;
  assign bus.space    = c_DEPTH - r_occupied;

endmodule
`default_nettype wire

// File: tb/tb_axis_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_axis_sync_fifo                                                  |
// | Directed and randomized-backpressure checks for axis_sync_fifo     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_axis_sync_fifo;
  localparam int WIDTH = 65;
  localparam int SIZE  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  axis_sync_fifo_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  axis_sync_fifo #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] crc_step(input logic [64:0] crc, input logic [64:0] w);
    return {crc[63:0], crc[64]} ^ w;
  endfunction

  logic [64:0] got[$];
  logic [64:0] q[$];
  logic [64:0] crc3;
  logic [64:0] crc;
  logic [64:0] expw;
  logic [64:0] prev_data;
  logic        prev_stall;
  logic        b;
  int          bad;
  int          max_occ;
  int          first_valid;
  int          rx;
  int          cyc;

  initial begin
    bus.i_tdata  = '0;
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_o_tvalid", bus.o_tvalid, 0);
    chk("rst_i_tready", bus.i_tready, 0);
    chk("rst_occupied", bus.occupied, 0);
    chk("rst_space", bus.space, 16);
    reset_n = 1'b1;
    tick();
    chk("rst_release_i_tready", bus.i_tready, 1);

    // Fill to capacity with o_tready low
    for (int i = 0; i < 16; i++) begin
      bus.i_tdata  = {(i == 15), 64'h100 + 64'(i)};
      bus.i_tvalid = 1'b1;
      tick();
      if (i == 0) chk("lat_k_o_tvalid", bus.o_tvalid, 0);
      if (i == 1) begin
        chk("lat_k1_o_tvalid", bus.o_tvalid, 1);
        chk("lat_k1_o_tdata", bus.o_tdata, {1'b0, 64'h100});
      end
    end
    chk("full_occupied", bus.occupied, 16);
    chk("full_space", bus.space, 0);
    chk("full_i_tready", bus.i_tready, 0);
    chk("full_o_tdata_hdr", bus.o_tdata, {1'b0, 64'h100});
    bus.i_tdata = {1'b1, 64'hDEAD};
    tick();
    chk("full_write_ignored", bus.occupied, 16);
    // Consume from full with a write presented: the write must be dropped
    bus.o_tready = 1'b1;
    tick();
    bus.i_tvalid = 1'b0;
    chk("full_consume_occ", bus.occupied, 15);
    chk("full_consume_i_tready", bus.i_tready, 1);
    for (int i = 1; i < 16; i++) begin
      expw = {(i == 15), 64'h100 + 64'(i)};
      chk("drain_o_tvalid", bus.o_tvalid, 1);
      chk("drain_o_tdata", bus.o_tdata, expw);
      tick();
    end
    chk("drained_o_tvalid", bus.o_tvalid, 0);
    chk("drained_occupied", bus.occupied, 0);
    chk("drained_space", bus.space, 16);

    // Concurrent single packet
    got.delete();
    max_occ     = 0;
    first_valid = -1;
    for (int c = 0; c < 30; c++) begin
      bus.i_tvalid = (c < 20);
      bus.i_tdata  = {(c == 19), 64'h200 + 64'(c)};
      if (bus.o_tvalid) got.push_back(bus.o_tdata);
      tick();
      if (int'(bus.occupied) > max_occ) max_occ = int'(bus.occupied);
      if (first_valid < 0 && bus.o_tvalid) first_valid = c;
    end
    bus.i_tvalid = 1'b0;
    chk("conc_first_valid", first_valid, 1);
    chk("conc_count", got.size(), 20);
    chk("conc_max_occ", max_occ, 2);
    bad  = 0;
    crc3 = '0;
    for (int k = 0; k < got.size(); k++) begin
      expw = {(k == 19), 64'h200 + 64'(k)};
      if (got[k] !== expw) bad++;
      crc3 = crc_step(crc3, got[k]);
    end
    chk("conc_words", bad, 0);

    // Ten packets with idle gaps
    for (int p = 0; p < 10; p++) begin
      got.delete();
      for (int c = 0; c < 50; c++) begin
        bus.i_tvalid = (c < 20);
        bus.i_tdata  = {(c == 19), 64'h200 + 64'(c)};
        if (bus.o_tvalid) got.push_back(bus.o_tdata);
        tick();
      end
      crc = '0;
      foreach (got[k]) crc = crc_step(crc, got[k]);
      chk("multi_count", got.size(), 20);
      chk("multi_crc", crc, crc3);
      chk("multi_gap_occ", bus.occupied, 0);
    end
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;

    // Clear mid-stream, with a write in the same cycle
    for (int i = 0; i < 8; i++) begin
      bus.i_tdata  = {1'b0, 64'h300 + 64'(i)};
      bus.i_tvalid = 1'b1;
      tick();
    end
    chk("pre_clear_occ", bus.occupied, 8);
    clear       = 1'b1;
    bus.i_tdata = {1'b0, 64'h3FF};
    tick();
    clear        = 1'b0;
    bus.i_tvalid = 1'b0;
    chk("clr_o_tvalid", bus.o_tvalid, 0);
    chk("clr_occupied", bus.occupied, 0);
    chk("clr_space", bus.space, 16);
    chk("clr_i_tready", bus.i_tready, 1);
    bus.i_tdata  = {1'b1, 64'h400};
    bus.i_tvalid = 1'b1;
    tick();
    bus.i_tvalid = 1'b0;
    chk("clr_new_k", bus.o_tvalid, 0);
    tick();
    chk("clr_new_k1_valid", bus.o_tvalid, 1);
    chk("clr_new_k1_data", bus.o_tdata, {1'b1, 64'h400});
    chk("clr_new_occ", bus.occupied, 1);
    bus.o_tready = 1'b1;
    tick();
    bus.o_tready = 1'b0;
    chk("clr_after_drain_valid", bus.o_tvalid, 0);
    chk("clr_after_drain_occ", bus.occupied, 0);

    // Reset mid-stream
    for (int i = 0; i < 8; i++) begin
      bus.i_tdata  = {1'b0, 64'h500 + 64'(i)};
      bus.i_tvalid = 1'b1;
      tick();
    end
    bus.i_tvalid = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("mrst_i_tready", bus.i_tready, 0);
    chk("mrst_o_tvalid", bus.o_tvalid, 0);
    chk("mrst_occupied", bus.occupied, 0);
    chk("mrst_space", bus.space, 16);
    reset_n = 1'b1;
    tick();
    chk("mrst_release_i_tready", bus.i_tready, 1);
    chk("mrst_release_o_tvalid", bus.o_tvalid, 0);
    bus.i_tdata  = {1'b0, 64'h600};
    bus.i_tvalid = 1'b1;
    tick();
    bus.i_tvalid = 1'b0;
    tick();
    chk("mrst_new_valid", bus.o_tvalid, 1);
    chk("mrst_new_data", bus.o_tdata, {1'b0, 64'h600});
    bus.o_tready = 1'b1;
    tick();
    bus.o_tready = 1'b0;
    chk("mrst_after_drain_occ", bus.occupied, 0);

    // Random valid/ready with wrap; scoreboard queue models contents
    q.delete();
    rx         = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (rx < 300 && cyc < 20000) begin
      b            = 1'($urandom_range(0, 1));
      bus.i_tvalid = ($urandom_range(0, 99) < 60);
      bus.i_tdata  = {b, $urandom(), $urandom()};
      bus.o_tready = ($urandom_range(0, 99) < 50);
      chk("rand_space_plus_occ", 128'(bus.space) + 128'(bus.occupied), 16);
      chk("rand_occ_model", bus.occupied, q.size());
      if (prev_stall) begin
        chk("rand_stall_valid", bus.o_tvalid, 1);
        chk("rand_stall_data", bus.o_tdata, prev_data);
      end
      if (bus.i_tvalid && bus.i_tready) q.push_back(bus.i_tdata);
      if (bus.o_tvalid && bus.o_tready) begin
        expw = (q.size() > 0) ? q.pop_front() : 'x;
        chk("rand_order", bus.o_tdata, expw);
        rx++;
      end
      prev_stall = bus.o_tvalid && !bus.o_tready;
      prev_data  = bus.o_tdata;
      tick();
      cyc++;
    end
    bus.i_tvalid = 1'b0;
    bus.o_tready = 1'b0;
    chk("rand_done", rx, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
